// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcodes, ALU op encodings and controller state names.
// Used by the multi-cycle control FSM and the instruction-class decoder.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_R  = 7'h33;
   localparam logic [6:0] OP_I  = 7'h13;
   localparam logic [6:0] OP_LW = 7'h03;
   localparam logic [6:0] OP_SW = 7'h23;
   localparam logic [6:0] OP_SB = 7'h63;
   localparam logic [6:0] OP_UJ = 7'h6F;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;

   typedef enum logic [2:0] {
      BOOT,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

endpackage

// File: rtl/multicycle_ctrl_ins_class_dec.sv
// Instruction-class decoder: combinational, zero latency, no flow control.
// Classifies the latched instruction and picks the ALU op (add unless R-type or branch).
module ins_class_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic        isRtype,
   output logic        isItype,
   output logic        isLw,
   output logic        isStype,
   output logic        isbranch_c,
   output logic        isjump_c,
   output logic        illegal_c,
   output logic [2:0]  alu_op
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       r_ok;
   logic       unused_fields;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];
   assign unused_fields = ^{ir[24:15], ir[11:7]};

   assign isRtype    = (opcode == OP_R);
   assign isItype    = (opcode == OP_I);
   assign isLw       = (opcode == OP_LW);
   assign isStype    = (opcode == OP_SW);
   assign isbranch_c = (opcode == OP_SB);
   assign isjump_c   = (opcode == OP_UJ);

   always_comb begin
      r_ok   = 1'b1;
      alu_op = ALU_ADD;
      if (isRtype) begin
         case ({funct7, funct3})
            {7'h00, 3'd0}: alu_op = ALU_ADD;
            {7'h20, 3'd0}: alu_op = ALU_SUB;
            {7'h00, 3'd2}: alu_op = ALU_SLT;
            {7'h00, 3'd7}: alu_op = ALU_AND;
            {7'h00, 3'd6}: alu_op = ALU_OR;
            default:       r_ok   = 1'b0;
         endcase
      end else if (isbranch_c) begin
         alu_op = ALU_SUB;
      end
   end

   // Unknown opcodes and R-type functs outside the supported set both count as illegal.
   assign illegal_c = ~(isRtype | isItype | isLw | isStype | isbranch_c | isjump_c)
                    | (isRtype & ~r_ok);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: 3-5 cycles per instruction, Moore outputs from state + IR.
// No backpressure: the datapath is assumed to complete every step in one cycle.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter logic [31:0] ENTRY     = 32'h28,
   parameter int          RUN_COUNT = 43,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ins,
   input  logic             zero,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic [2:0]       op,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic             INT,
   output logic [31:0]      entryPoint,
   output logic             isbranch,
   output logic             isjump,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic             done
);

   localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_COUNT);

   state_t      state;
   state_t      seq_nxt;
   state_t      state_nxt;
   logic [31:0] ir;
   logic        isRtype;
   logic        isItype;
   logic        isLw;
   logic        isStype;
   logic        isbranch_c;
   logic        isjump_c;
   logic        illegal_c;
   logic [2:0]  alu_op;
   logic        count_pulse;
   logic        at_max;
   logic        halt_hit;
   logic        unused_zero;

   // The branch decision on zero is made by yPC, not here.
   assign unused_zero = zero;
   assign entryPoint  = ENTRY;

   ins_class_dec u_dec (
      .ir         (ir),
      .isRtype    (isRtype),
      .isItype    (isItype),
      .isLw       (isLw),
      .isStype    (isStype),
      .isbranch_c (isbranch_c),
      .isjump_c   (isjump_c),
      .illegal_c  (illegal_c),
      .alu_op     (alu_op)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= BOOT;
         ir      <= '0;
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == FETCH) begin
            ir <= ins;
         end
         if (state == EXEC && illegal_c) begin
            illegal <= 1'b1;
         end
         if (count_pulse && !at_max) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      seq_nxt  = state;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b1;
      op       = ALU_ADD;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      INT      = 1'b0;
      isbranch = 1'b0;
      isjump   = 1'b0;
      done     = 1'b0;
      case (state)
         BOOT: begin
            INT     = 1'b1;
            PCWrite = 1'b1;
            seq_nxt = FETCH;
         end
         FETCH: begin
            IRWrite = 1'b1;
            seq_nxt = DECODE;
         end
         DECODE: begin
            seq_nxt = EXEC;
         end
         EXEC: begin
            ALUSrc = ~(isRtype | isbranch_c);
            op     = alu_op;
            if (isRtype || isItype) begin
               seq_nxt = WB;
            end else if (isLw || isStype) begin
               seq_nxt = MEM;
            end else begin
               // Branch, jump and unknown opcodes all finish here.
               PCWrite  = 1'b1;
               isbranch = isbranch_c;
               isjump   = isjump_c;
               seq_nxt  = FETCH;
            end
         end
         MEM: begin
            op = alu_op;
            if (isLw) begin
               MemRead = 1'b1;
               seq_nxt = WB;
            end else begin
               MemWrite = 1'b1;
               PCWrite  = 1'b1;
               seq_nxt  = FETCH;
            end
         end
         WB: begin
            // ALU inputs stay steady so z is still valid while it is written back.
            ALUSrc   = ~isRtype;
            op       = alu_op;
            RegWrite = ~illegal_c;
            Mem2Reg  = isLw;
            PCWrite  = 1'b1;
            seq_nxt  = FETCH;
         end
         HALT: begin
            done    = 1'b1;
            seq_nxt = HALT;
         end
         default: begin
            seq_nxt = BOOT;
         end
      endcase
   end

   assign count_pulse = PCWrite && (state != BOOT);
   assign at_max      = &retired;
   assign halt_hit    = (RUN_COUNT != 0) && count_pulse && !at_max
                      && ((retired + CNT_W'(1)) == RUN_LIM);
   assign state_nxt   = halt_hit ? HALT : seq_nxt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle tables built from the opcode rules,
// compared every cycle against the DUT and a saturating-counter twin.
module tb_multicycle_ctrl;

   localparam int RUNS = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        zero = 1'b0;
   logic [31:0] ins = '0;

   logic        IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, INT;
   logic        isbranch, isjump, illegal, done;
   logic [2:0]  op;
   logic [31:0] entryPoint;
   logic [15:0] retired;

   logic        IRWrite2, PCWrite2, RegWrite2, ALUSrc2, MemRead2, MemWrite2, Mem2Reg2, INT2;
   logic        isbranch2, isjump2, illegal2, done2;
   logic [2:0]  op2;
   logic [31:0] entryPoint2;
   logic [0:0]  retired2;

   always #5 clk = ~clk;

   multicycle_ctrl #(.ENTRY(32'h28), .RUN_COUNT(RUNS), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .ins(ins), .zero(zero),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
      .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .INT(INT),
      .entryPoint(entryPoint), .isbranch(isbranch), .isjump(isjump), .illegal(illegal),
      .retired(retired), .done(done)
   );

   // Free-running twin with a 1-bit counter to exercise saturation.
   multicycle_ctrl #(.ENTRY(32'h28), .RUN_COUNT(0), .CNT_W(1)) dut_sat (
      .clk(clk), .reset(reset), .ins(ins), .zero(zero),
      .IRWrite(IRWrite2), .PCWrite(PCWrite2), .RegWrite(RegWrite2), .ALUSrc(ALUSrc2), .op(op2),
      .MemRead(MemRead2), .MemWrite(MemWrite2), .Mem2Reg(Mem2Reg2), .INT(INT2),
      .entryPoint(entryPoint2), .isbranch(isbranch2), .isjump(isjump2), .illegal(illegal2),
      .retired(retired2), .done(done2)
   );

   typedef struct packed {
      logic       irw, pcw, rw, asrc;
      logic [2:0] op;
      logic       mr, mw, m2r, intr, isb, isj, dn;
   } outs_t;

   typedef struct {
      outs_t       o;
      logic [31:0] w;
      bit          f;
      int          r;
      bit          il;
      bit          h;
   } cyc_t;

   cyc_t        cq[$];
   logic [31:0] prog[$];
   int          m_ret;
   bit          m_ill;
   bit          m_halt;
   int          n_chk = 0;
   int          n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic outs_t base();
      outs_t o;
      o = '0;
      o.asrc = 1'b1;
      o.op = 3'b010;
      return o;
   endfunction

   function automatic outs_t dut_outs();
      return {IRWrite, PCWrite, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg,
              INT, isbranch, isjump, done};
   endfunction

   task automatic push(input outs_t o, input logic [31:0] w, input bit f,
                       input bit ret, input bit setill, input bit h);
      cyc_t c;
      c.o = o; c.w = w; c.f = f; c.r = m_ret; c.il = m_ill; c.h = h;
      cq.push_back(c);
      if (ret) begin
         m_ret++;
         if (m_ret == RUNS) m_halt = 1'b1;
      end
      if (setill) m_ill = 1'b1;
   endtask

   // Cycle table for one instruction, straight from the opcode/funct rules.
   task automatic add_instr(input logic [31:0] w);
      outs_t      o;
      logic [2:0] aop;
      bit         good;
      o = base(); o.irw = 1'b1; push(o, w, 1, 0, 0, 0);
      o = base();               push(o, '0, 0, 0, 0, 0);
      case (w[6:0])
         7'h33: begin
            good = 1'b1;
            case ({w[31:25], w[14:12]})
               {7'h00, 3'd0}: aop = 3'b010;
               {7'h20, 3'd0}: aop = 3'b110;
               {7'h00, 3'd2}: aop = 3'b011;
               {7'h00, 3'd7}: aop = 3'b000;
               {7'h00, 3'd6}: aop = 3'b001;
               default: begin aop = 3'b010; good = 1'b0; end
            endcase
            o = base(); o.asrc = 1'b0; o.op = aop; push(o, '0, 0, 0, !good, 0);
            o.rw = good; o.pcw = 1'b1;            push(o, '0, 0, 1, 0, 0);
         end
         7'h13: begin
            o = base();                         push(o, '0, 0, 0, 0, 0);
            o.rw = 1'b1; o.pcw = 1'b1;          push(o, '0, 0, 1, 0, 0);
         end
         7'h03: begin
            o = base();                         push(o, '0, 0, 0, 0, 0);
            o.mr = 1'b1;                        push(o, '0, 0, 0, 0, 0);
            o = base(); o.rw = 1'b1; o.m2r = 1'b1; o.pcw = 1'b1; push(o, '0, 0, 1, 0, 0);
         end
         7'h23: begin
            o = base();                         push(o, '0, 0, 0, 0, 0);
            o.mw = 1'b1; o.pcw = 1'b1;          push(o, '0, 0, 1, 0, 0);
         end
         7'h63: begin
            o = base(); o.asrc = 1'b0; o.op = 3'b110; o.isb = 1'b1; o.pcw = 1'b1;
            push(o, '0, 0, 1, 0, 0);
         end
         7'h6F: begin
            o = base(); o.isj = 1'b1; o.pcw = 1'b1; push(o, '0, 0, 1, 0, 0);
         end
         default: begin
            o = base(); o.pcw = 1'b1;           push(o, '0, 0, 1, 1, 0);
         end
      endcase
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] w;
      logic [6:0]  opc;
      w = $urandom;
      case ($urandom_range(0, 7))
         0: begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 4))
               0: {w[31:25], w[14:12]} = {7'h00, 3'd0};
               1: {w[31:25], w[14:12]} = {7'h20, 3'd0};
               2: {w[31:25], w[14:12]} = {7'h00, 3'd2};
               3: {w[31:25], w[14:12]} = {7'h00, 3'd7};
               default: {w[31:25], w[14:12]} = {7'h00, 3'd6};
            endcase
         end
         1: begin
            w[6:0] = 7'h33;
            w[31:25] = 7'h20;
            w[14:12] = 3'($urandom_range(1, 7));
         end
         2: w[6:0] = 7'h13;
         3: w[6:0] = 7'h03;
         4: w[6:0] = 7'h23;
         5: w[6:0] = 7'h63;
         6: w[6:0] = 7'h6F;
         default: begin
            opc = 7'($urandom);
            while (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23 ||
                   opc == 7'h63 || opc == 7'h6F)
               opc = 7'($urandom);
            w[6:0] = opc;
         end
      endcase
      return w;
   endfunction

   task automatic run_episode(input int abort_at);
      outs_t boot_o;
      outs_t o;
      cq.delete();
      m_ret = 0; m_ill = 1'b0; m_halt = 1'b0;
      boot_o = base(); boot_o.intr = 1'b1; boot_o.pcw = 1'b1;
      push(boot_o, '0, 0, 0, 0, 0);
      foreach (prog[i]) if (!m_halt) add_instr(prog[i]);
      if (m_halt) begin
         for (int k = 0; k < 3; k++) begin
            o = base(); o.dn = 1'b1; push(o, '0, 0, 0, 0, 1);
         end
      end

      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_outs", 32'(dut_outs()), 32'(boot_o));
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("entry", entryPoint, 32'h28);
      reset = 1'b0;

      for (int i = 0; i < cq.size(); i++) begin
         ins  = cq[i].f ? cq[i].w : $urandom;
         zero = 1'($urandom);
         chk($sformatf("outs[%0d]", i), 32'(dut_outs()), 32'(cq[i].o));
         chk($sformatf("retired[%0d]", i), 32'(retired), 32'(cq[i].r));
         chk($sformatf("illegal[%0d]", i), 32'(illegal), 32'(cq[i].il));
         if (!cq[i].h) begin
            chk($sformatf("sat_retired[%0d]", i), 32'(retired2), (cq[i].r > 1) ? 32'd1 : 32'(cq[i].r));
            chk($sformatf("sat_done[%0d]", i), 32'(done2), 32'd0);
         end
         if (i == abort_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            chk("abort_outs", 32'(dut_outs()), 32'(boot_o));
            chk("abort_retired", 32'(retired), 32'd0);
            chk("abort_illegal", 32'(illegal), 32'd0);
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // add, lw, sw
      prog.delete();
      prog.push_back(32'h002081B3); prog.push_back(32'h00002283); prog.push_back(32'h00502223);
      run_episode(-1);
      // two beq, then an unknown opcode
      prog.delete();
      prog.push_back(32'h00208463); prog.push_back(32'h00208463); prog.push_back(32'h0000007F);
      run_episode(-1);
      // three addi reach the run limit
      prog.delete();
      prog.push_back(32'h00100093); prog.push_back(32'h00200113); prog.push_back(32'h00300193);
      run_episode(-1);
      // unsupported funct, then jal
      prog.delete();
      prog.push_back(32'h022081B3); prog.push_back(32'h0000006F); prog.push_back(32'h00100093);
      run_episode(-1);
      // reset lands in the MEM cycle of the lw
      prog.delete();
      prog.push_back(32'h00100093); prog.push_back(32'h00002283);
      run_episode(8);

      for (int ep = 0; ep < 40; ep++) begin
         prog.delete();
         for (int k = 0; k < 3; k++) prog.push_back(rand_ins());
         run_episode(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the yIF/yID/yEX/yDM/yWB/yPC RISC-V datapath.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Generates every datapath control signal that the single-cycle bench currently drives by hand.
- Sits between the instruction word / ALU zero flag and the datapath enables.

Parameters:
ENTRY, 32'h28, PC loaded via entryPoint/INT on leaving reset
RUN_COUNT, 43, instructions retired before HALT; 0 = run forever
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
ins  in  32  instruction word from yIF
zero  in  1  ALU zero flag from yEX
IRWrite  out  1  latch ins into the instruction register (FETCH)
PCWrite  out  1  one-cycle PC update strobe, last state of each instruction
RegWrite  out  1  register-file write enable
ALUSrc  out  1  0 = rd2, 1 = imm
op  out  3  ALU op: 010 add, 110 sub, 011 slt, 000 and, 001 or
MemRead  out  1  data-memory read
MemWrite  out  1  data-memory write
Mem2Reg  out  1  1 = write back memOut, 0 = ALU z
INT  out  1  select entryPoint into PCin
entryPoint  out  32  constant ENTRY
isbranch  out  1  SB-type in EXEC
isjump  out  1  UJ-type in EXEC
illegal  out  1  sticky; unknown opcode or unsupported funct seen
retired  out  CNT_W  count of completed instructions
done  out  1  high in HALT

Behaviour:
Reset:
- reset high at an edge → state BOOT, retired = 0, illegal = 0, instruction register = 0.
- Reset mid-instruction aborts that instruction with no partial write.
- Reset values: INT = 1 and PCWrite = 1 (BOOT); all other strobes 0; op = 010; ALUSrc = 1; done = 0.

Outputs:
- Moore outputs, decoded from state plus the latched instruction register.
- ins is sampled only in FETCH.

State transitions:
- BOOT: INT = 1 and PCWrite = 1 for one cycle, then FETCH.
- FETCH: IRWrite = 1, then DECODE.
- DECODE: classify opcode, then EXEC.
- EXEC:
  - R (0x33): ALUSrc = 0; op from funct7/funct3: (00,0) add, (20,0) sub, (00,2) slt, (00,7) and, (00,6) or. Next WB.
  - I-ALU (0x13): ALUSrc = 1, op add. Next WB.
  - LW (0x03) and SW (0x23): ALUSrc = 1, op add. Next MEM.
  - SB (0x63): ALUSrc = 0, op sub, isbranch = 1, PCWrite = 1 (yPC chooses the branch target from zero). Next FETCH.
  - UJ (0x6F): isjump = 1, PCWrite = 1, no link write. Next FETCH.
  - Any other opcode: NOP; set illegal; PCWrite = 1. Next FETCH.
  - Unsupported R funct: op = add, RegWrite suppressed, illegal set.
- MEM:
  - LW: MemRead = 1, then WB.
  - SW: MemWrite = 1, PCWrite = 1, then FETCH.
  - ALUSrc and op are held from EXEC.
- WB: RegWrite = 1, Mem2Reg = 1 for LW else 0, PCWrite = 1, then FETCH.

Latency (FETCH to next FETCH):
- R and I-ALU: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- SB and UJ: 3 cycles.

Retire counter:
- retired increments on every PCWrite except the BOOT pulse.
- Saturates at 2^CNT_W − 1.
- When RUN_COUNT ≠ 0 and the increment makes retired == RUN_COUNT, the next state is HALT instead of FETCH.

HALT:
- All strobes 0, done = 1.
- Stays in HALT until reset.

Other boundary rules:
- zero is used only by yPC in EXEC of SB; it is ignored elsewhere.
- ins changing outside FETCH has no effect.

Decomposition:
- Shared package:
  - Opcode constants OP_R 0x33, OP_I 0x13, OP_LW 0x03, OP_SW 0x23, OP_SB 0x63, OP_UJ 0x6F.
  - ALU op codes.
  - State enum BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT.
- One combinational sub-module, ins_class_dec: takes the instruction register and outputs isRtype/isItype/isLw/isStype/isbranch_c/isjump_c/illegal_c plus the ALU op.

Test Plan:
- Reset held 2 cycles, then released → INT = 1 and PCWrite = 1 for exactly one cycle, entryPoint = 0x28, then IRWrite = 1 on the next cycle.
- add x3,x1,x2 (0x002081B3) → FETCH/DECODE/EXEC/WB; op = 010, ALUSrc = 0; RegWrite = 1 only in WB; retired 0 → 1 after 4 cycles.
- lw x5,0(x0) then sw x5,4(x0):
  - lw: MemRead in cycle 4, RegWrite + Mem2Reg in cycle 5.
  - sw: MemWrite = 1 in its MEM cycle, no RegWrite.
- beq (0x00208463) with zero = 1, then with zero = 0 → isbranch = 1, op = 110, ALUSrc = 0 in EXEC; 3-cycle instruction both times.
- Opcode 0x7F → illegal goes high and stays high; no RegWrite/MemWrite; retired still increments.
- RUN_COUNT = 3 with three addi instructions → done = 1 after the 3rd WB; reset asserted during a later lw MEM cycle → BOOT with no MemRead the following cycle.
